// File: rtl/stream_comparator.sv
// stream_comparator: two-stage elastic pipeline that compares operand pairs
// (signed or unsigned) and keeps saturating counts of gt/lt/eq results.
module stream_comparator #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 gt,
   output logic                 lt,
   output logic                 eq,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] gt_count,
   output logic [CNT_WIDTH-1:0] lt_count,
   output logic [CNT_WIDTH-1:0] eq_count
);

   localparam int STAGES = 2;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sm;
   } req_t;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } rsp_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [STAGES:1]         vld_pipe;
   req_t                    s1;
   rsp_t                    s2;
   rsp_t                    cmp;
   logic                    s2_adv;
   logic                    out_fire;
   logic signed [WIDTH:0]   ea;
   logic signed [WIDTH:0]   eb;
   logic [CNT_WIDTH-1:0]    cnt [3];

   // S2 takes a new value when it is empty or its result leaves this cycle;
   // S1 drains into S2 on exactly the same condition.
   assign s2_adv   = !vld_pipe[2] || out_ready;
   assign out_fire = vld_pipe[2] && out_ready;
   assign in_ready = n_rst && (!vld_pipe[1] || s2_adv);

   // Extend by one bit: sign-extend in signed mode, zero-extend otherwise,
   // so one signed compare covers both modes.
   assign ea = $signed({s1.sm & s1.a[WIDTH-1], s1.a});
   assign eb = $signed({s1.sm & s1.b[WIDTH-1], s1.b});

   // Result of the pair held in S1; all-zero when S1 is empty.
   always_comb begin
      cmp    = '0;
      cmp.gt = vld_pipe[1] && (ea > eb);
      cmp.lt = vld_pipe[1] && (ea < eb);
      cmp.eq = vld_pipe[1] && (ea == eb);
   end

   // Pipeline registers: S1 holds operands, S2 holds the registered result.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
      end else begin
         if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) s1 <= '{a: a, b: b, sm: signed_mode};
         end
         if (s2_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            s2          <= cmp;
         end
      end
   end

   assign out_valid = vld_pipe[2];
   assign gt        = s2.gt;
   assign lt        = s2.lt;
   assign eq        = s2.eq;

   // Saturating event counters, bumped per output transfer; clear wins.
   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else if (out_fire) begin
         if (s2.gt && cnt[0] != '1) cnt[0] <= cnt[0] + CNT_ONE;
         if (s2.lt && cnt[1] != '1) cnt[1] <= cnt[1] + CNT_ONE;
         if (s2.eq && cnt[2] != '1) cnt[2] <= cnt[2] + CNT_ONE;
      end
   end

   assign gt_count = cnt[0];
   assign lt_count = cnt[1];
   assign eq_count = cnt[2];

endmodule

// File: tb/tb_stream_comparator.sv
// tb_stream_comparator: directed vectors with hand-computed results.
module tb_stream_comparator;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [15:0] a, b;
   logic        signed_mode, in_valid, in_ready;
   logic        gt, lt, eq, out_valid, out_ready, clear;
   logic [7:0]  gt_count, lt_count, eq_count;

   int total = 0;
   int bad   = 0;

   stream_comparator #(.WIDTH(16), .CNT_WIDTH(8)) dut (
      .clk(clk), .n_rst(n_rst), .a(a), .b(b), .signed_mode(signed_mode),
      .in_valid(in_valid), .in_ready(in_ready), .gt(gt), .lt(lt), .eq(eq),
      .out_valid(out_valid), .out_ready(out_ready), .clear(clear),
      .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance one edge, settle 1ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [15:0] ta, input logic [15:0] tb_, input logic sm);
      a = ta; b = tb_; signed_mode = sm; in_valid = 1'b1;
   endtask

   task automatic res(input string tag, input logic v, input logic g, input logic l, input logic e);
      chk({tag, "_v"},  out_valid, v);
      chk({tag, "_gt"}, gt, g);
      chk({tag, "_lt"}, lt, l);
      chk({tag, "_eq"}, eq, e);
   endtask

   task automatic cnts(input string tag, input int g, input int l, input int e);
      chk({tag, "_gtc"}, gt_count, g);
      chk({tag, "_ltc"}, lt_count, l);
      chk({tag, "_eqc"}, eq_count, e);
   endtask

   initial begin
      int xfers, stalls, stale;
      n_rst = 1'b0; a = '0; b = '0; signed_mode = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1; clear = 1'b0;
      #1;
      tick(); tick();
      // reset state
      chk("rst_in_ready", in_ready, 1'b0);
      res("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      cnts("rst", 0, 0, 0);
      n_rst = 1'b1;
      #1 chk("rel_in_ready", in_ready, 1'b1);

      // equal pair, unsigned, 2-cycle latency
      put(16'h1234, 16'h1234, 1'b0);
      #1 chk("eq_in_ready", in_ready, 1'b1);
      tick(); in_valid = 1'b0;
      chk("eq_lat1_v", out_valid, 1'b0);
      tick();
      res("eq", 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("eq_after_v", out_valid, 1'b0);
      cnts("eq", 0, 0, 1);

      // signed vs unsigned, mode travels with the pair
      put(16'hFFFF, 16'h0000, 1'b1); tick();
      put(16'hFFFF, 16'h0000, 1'b0); tick();
      res("sgn_ffff", 1'b1, 1'b0, 1'b1, 1'b0);
      put(16'h8000, 16'h0001, 1'b1); tick();
      res("uns_ffff", 1'b1, 1'b1, 1'b0, 1'b0);
      put(16'h8000, 16'h0001, 1'b0); tick();
      in_valid = 1'b0;
      res("sgn_8000", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      res("uns_8000", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("sgn_drain_v", out_valid, 1'b0);
      cnts("sgn", 2, 2, 1);

      // backpressure: 3 pairs, out_ready low
      out_ready = 1'b0;
      put(16'd5, 16'd3, 1'b0);
      #1 chk("bp_rdy0", in_ready, 1'b1);
      tick();
      put(16'd3, 16'd5, 1'b0);
      #1 chk("bp_rdy1", in_ready, 1'b1);
      tick();
      put(16'd7, 16'd7, 1'b0);
      #1 chk("bp_rdy2", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         res("bp_hold", 1'b1, 1'b1, 1'b0, 1'b0);
         chk("bp_hold_rdy", in_ready, 1'b0);
      end
      cnts("bp_hold", 2, 2, 1);
      out_ready = 1'b1;
      #1 chk("bp_release_rdy", in_ready, 1'b1);
      tick(); in_valid = 1'b0;
      res("bp_r1", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      res("bp_r2", 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("bp_drain_v", out_valid, 1'b0);
      cnts("bp", 3, 3, 2);

      // clear beats a same-cycle eq transfer
      put(16'd9, 16'd9, 1'b0); tick(); in_valid = 1'b0; tick();
      res("clr_pre", 1'b1, 1'b0, 1'b0, 1'b1);
      clear = 1'b1;
      tick(); clear = 1'b0;
      chk("clr_v", out_valid, 1'b0);
      cnts("clr", 0, 0, 0);

      // 300 gt results streaming: full throughput, counter saturates
      xfers = 0; stalls = 0;
      put(16'd2, 16'd1, 1'b0);
      for (int i = 0; i < 302; i++) begin
         if (i == 300) in_valid = 1'b0;
         if (in_valid && !in_ready) stalls++;
         tick();
         if (out_valid && out_ready) xfers++;
      end
      chk("sat_xfers", xfers, 300);
      chk("sat_stalls", stalls, 0);
      cnts("sat", 255, 0, 0);

      // reset with 2 pairs in flight
      out_ready = 1'b0;
      put(16'd1, 16'd4, 1'b0); tick();
      put(16'd4, 16'd1, 1'b0); tick();
      in_valid = 1'b0;
      chk("mid_pre_v", out_valid, 1'b1);
      n_rst = 1'b0;
      #1 chk("mid_rst_rdy", in_ready, 1'b0);
      tick();
      res("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      cnts("mid_rst", 0, 0, 0);
      n_rst = 1'b1; out_ready = 1'b1;
      #1 chk("mid_rel_rdy", in_ready, 1'b1);
      stale = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid) stale++;
      end
      chk("mid_stale", stale, 0);
      cnts("mid_after", 0, 0, 0);
      put(16'd1, 16'd2, 1'b0); tick(); in_valid = 1'b0; tick();
      res("post", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      cnts("post", 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
